onchip_mem_stream_master: RTL and testbench

- Avalon-MM master that drives the single-port 4096x32 on-chip memory slave from the opposite side.
- Converts a command (start address, word count, direction) into a sequence of memory accesses.
- Read direction: streams read words out on a ready/valid source with backpressure.
- Write direction: accepts words from a ready/valid sink and writes them to consecutive addresses.
- Sits between the video pipeline/CPU-side control logic and the on-chip memory.

---
 rtl/onchip_mem_stream_master_if.sv | 51 +++++
 rtl/onchip_mem_stream_master.sv | 186 ++++++++++++++++++
 tb/tb_onchip_mem_stream_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_stream_master_if.sv
// Bundle of command, status, memory-slave and stream signals for the
// on-chip memory stream master. "master" is the view of the block itself;
// "slave" is the view of whatever surrounds it (control, memory, streams).
interface onchip_mem_stream_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // command / status
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_count;
  logic              busy;
  logic              done;
  // Avalon-MM side towards the memory slave
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;
  // read stream source
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  // write stream sink
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_count,
    input  mem_readdata, out_ready, in_valid, in_data,
    output cmd_ready, busy, done,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    output out_valid, out_data, out_last, in_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_count,
    output mem_readdata, out_ready, in_valid, in_data,
    input  cmd_ready, busy, done,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    input  out_valid, out_data, out_last, in_ready
  );
endinterface

// File: rtl/onchip_mem_stream_master.sv
// Avalon-MM master for a single-port latency-1 on-chip memory. A command
// (start address, word count, direction) becomes a run of full-word
// accesses at consecutive, wrapping addresses. Reads are streamed out of a
// small return FIFO with backpressure; writes are taken from a stream sink.
// All memory-side outputs are registered, so a read decided in cycle t is
// presented in t+1 and its data is pushed at the end of t+2. The credit
// check therefore counts both the read being presented and the read whose
// data is returning, which keeps the FIFO from ever overflowing.
module onchip_mem_stream_master #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  onchip_mem_stream_master_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RD_DRAIN = 2'd2, WR = 2'd3} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;            // next address to access
  logic [ADDR_W:0]     remaining_reg, remaining_next;  // reads to issue / words to accept
  logic [ADDR_W:0]     beats_left_reg, beats_left_next;// stream beats still owed
  logic                done_reg, done_next;
  logic                cs_reg, cs_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   maddr_reg, maddr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W/8-1:0] be_reg;
  logic                clken_reg;
  logic                rd_return_reg;                  // mem_readdata valid this cycle

  // return FIFO
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]      fifo_count_reg;
  logic                fifo_empty, push, pop;
  logic                read_presented, credit_ok, in_ready_int;
  logic [PTR_W+1:0]    pending;

  assign fifo_empty     = (fifo_count_reg == '0);
  assign push           = rd_return_reg;
  assign pop            = !fifo_empty && bus.out_ready;
  assign read_presented = cs_reg && !we_reg;
  assign in_ready_int   = (state_reg == WR) && (remaining_reg != '0);

  // Words already buffered plus every read that will still land in the FIFO.
  assign pending   = {1'b0, fifo_count_reg}
                   + {{(PTR_W+1){1'b0}}, read_presented}
                   + {{(PTR_W+1){1'b0}}, rd_return_reg};
  assign credit_ok = (pending < (PTR_W+2)'(FIFO_DEPTH));

  assign bus.cmd_ready      = (state_reg == IDLE);
  assign bus.busy           = (state_reg != IDLE);
  assign bus.done           = done_reg;
  assign bus.mem_address    = maddr_reg;
  assign bus.mem_byteenable = be_reg;
  assign bus.mem_chipselect = cs_reg;
  assign bus.mem_write      = we_reg;
  assign bus.mem_writedata  = wdata_reg;
  assign bus.mem_clken      = clken_reg;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_mem[rd_ptr_reg];
  assign bus.out_last       = !fifo_empty && (beats_left_reg == (ADDR_W+1)'(1));
  assign bus.in_ready       = in_ready_int;

  // FIFO storage: written only when returning read data arrives.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.mem_readdata;
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Next-state and next-access decision for the transfer FSM.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    remaining_next  = remaining_reg;
    beats_left_next = pop ? beats_left_reg - 1'b1 : beats_left_reg;
    done_next       = 1'b0;
    cs_next         = 1'b0;
    we_next         = 1'b0;
    maddr_next      = maddr_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_count == '0) begin
            done_next = 1'b1;
          end else if (bus.cmd_write) begin
            state_next     = WR;
            addr_next      = bus.cmd_addr;
            remaining_next = bus.cmd_count;
          end else begin
            // The first read goes out straight away: the FIFO is empty here.
            state_next      = RD;
            cs_next         = 1'b1;
            maddr_next      = bus.cmd_addr;
            addr_next       = bus.cmd_addr + 1'b1;
            remaining_next  = bus.cmd_count - 1'b1;
            beats_left_next = bus.cmd_count;
          end
        end
      end
      RD: begin
        if ((remaining_reg != '0) && credit_ok) begin
          cs_next        = 1'b1;
          maddr_next     = addr_reg;
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
        end
        if (remaining_next == '0) state_next = RD_DRAIN;
      end
      RD_DRAIN: begin
        // The final beat leaving means the FIFO is empty and nothing is in flight.
        if (pop && (beats_left_reg == (ADDR_W+1)'(1))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      WR: begin
        if (bus.in_valid && in_ready_int) begin
          cs_next        = 1'b1;
          we_next        = 1'b1;
          maddr_next     = addr_reg;
          wdata_next     = bus.in_data;
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
        end else if (remaining_reg == '0) begin
          // The last write is on the bus this cycle.
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and registered memory-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      remaining_reg  <= '0;
      beats_left_reg <= '0;
      done_reg       <= 1'b0;
      cs_reg         <= 1'b0;
      we_reg         <= 1'b0;
      maddr_reg      <= '0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      clken_reg      <= 1'b0;
      rd_return_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      remaining_reg  <= remaining_next;
      beats_left_reg <= beats_left_next;
      done_reg       <= done_next;
      cs_reg         <= cs_next;
      we_reg         <= we_next;
      maddr_reg      <= maddr_next;
      wdata_reg      <= wdata_next;
      be_reg         <= cs_next ? '1 : '0;
      clken_reg      <= 1'b1;
      rd_return_reg  <= read_presented;
    end
  end
endmodule

// File: tb/tb_onchip_mem_stream_master.sv
// Directed bench: a table of commands with hand-computed expectations is run
// against a latency-1 memory model; a reference image of the memory tracks
// what the bench itself wrote. A mid-read reset is exercised by hand.
module tb_onchip_mem_stream_master;
  logic clk = 1'b0;
  logic reset;
  logic preload;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  onchip_mem_stream_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  onchip_mem_stream_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // memory slave model, fixed read latency 1
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'(i);
    end else if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      else               bus.mem_readdata     <= mem[bus.mem_address];
    end
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [12:0] count;
    int          mode;       // 0: ready/valid held high, 1: high every third cycle
    logic [31:0] base;       // first write word
    int          exp_beats;
    int          exp_cs;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int cyc, beat, widx, cs_cnt, done_cnt, done_cyc, first_valid_cyc;
    int last_beat_cyc, last_acc_cyc, max_occ, wait_cyc, limit;
    logic [31:0] first_d, last_d, prev_data;
    logic [11:0] a;
    logic prev_stall, rdy;
    beat = 0; widx = 0; cs_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_valid_cyc = -1; last_beat_cyc = -1; last_acc_cyc = -1; max_occ = 0;
    first_d = '0; last_d = '0; prev_data = '0; prev_stall = 1'b0;
    @(negedge clk);
    wait_cyc = 0;
    while (!bus.cmd_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    limit = int'(v.count) * 4 + 60;
    for (cyc = 0; cyc < limit; cyc++) begin
      if (cyc != 0) @(negedge clk);
      rdy           = (v.mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.cmd_valid = (cyc == 0);
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_count = v.count;
      bus.out_ready = rdy;
      bus.in_valid  = v.wr && (widx < int'(v.count)) && rdy;
      bus.in_data   = v.base + 32'(widx);
      if (cyc == 1 && v.count != 0) chk("busy_after_accept", bus.busy, 1);
      if (bus.mem_chipselect) begin
        a = v.addr + 12'(cs_cnt);
        chk("mem_byteenable", bus.mem_byteenable, 4'hF);
        chk("mem_write_dir", bus.mem_write, v.wr);
        chk("mem_address", bus.mem_address, a);
        if (v.wr) begin
          chk("mem_writedata", bus.mem_writedata, v.base + 32'(cs_cnt));
          if (cs_cnt == 0) first_d = bus.mem_writedata;
          last_d = bus.mem_writedata;
        end
        cs_cnt++;
      end
      if (int'(dut.fifo_count_reg) > max_occ) max_occ = int'(dut.fifo_count_reg);
      if (prev_stall) chk("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rdy) begin
          a = v.addr + 12'(beat);
          chk("out_data", bus.out_data, ref_mem[a]);
          chk("out_last", bus.out_last, beat == int'(v.count) - 1);
          if (beat == 0) first_d = bus.out_data;
          last_d = bus.out_data;
          last_beat_cyc = cyc;
          beat++;
        end
      end
      prev_stall = bus.out_valid && !rdy;
      prev_data  = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        widx++;
        last_acc_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_low_at_done", bus.busy, 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (v.wr) begin
      for (int i = 0; i < int'(v.count); i++) begin
        a = v.addr + 12'(i);
        ref_mem[a] = v.base + 32'(i);
      end
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_once", done_cnt, 1);
    chk("chipselect_count", cs_cnt, v.exp_cs);
    if (!v.wr) chk("beat_count", beat, v.exp_beats);
    if (v.count == 0) begin
      chk("zero_count_done_cycle", done_cyc, 1);
    end else begin
      chk("first_word", first_d, v.exp_first);
      chk("last_word", last_d, v.exp_last);
      if (!v.wr) begin
        chk("first_valid_latency", first_valid_cyc, 3);
        chk("done_after_last_beat", done_cyc, last_beat_cyc + 1);
        if (v.mode == 0) chk("read_throughput", last_beat_cyc, 3 + int'(v.count) - 1);
        chk("fifo_occupancy_max", max_occ <= 4, 1);
      end else begin
        chk("words_taken", widx, int'(v.count));
        chk("done_after_last_write", done_cyc, last_acc_cyc + 2);
      end
    end
    $display("cmd %0d: %s addr=0x%03h count=%0d beats=%0d cs=%0d done_cyc=%0d max_occ=%0d",
             idx, v.wr ? "write" : "read ", v.addr, v.count, beat, cs_cnt, done_cyc, max_occ);
  endtask

  vec_t vecs [9];
  vec_t after_rst;
  int   beats;

  initial begin
    vecs[0] = '{1'b0, 12'h010, 13'd4,    0, 32'h0,  4,    4,    32'h10,  32'h13};
    vecs[1] = '{1'b1, 12'hFFE, 13'd4,    0, 32'hA0, 0,    4,    32'hA0,  32'hA3};
    vecs[2] = '{1'b0, 12'hFFE, 13'd4,    0, 32'h0,  4,    4,    32'hA0,  32'hA3};
    vecs[3] = '{1'b0, 12'h020, 13'd16,   1, 32'h0,  16,   16,   32'h20,  32'h2F};
    vecs[4] = '{1'b0, 12'h000, 13'd0,    0, 32'h0,  0,    0,    32'h0,   32'h0};
    vecs[5] = '{1'b1, 12'h100, 13'd0,    0, 32'h0,  0,    0,    32'h0,   32'h0};
    vecs[6] = '{1'b1, 12'h200, 13'd3,    1, 32'h55, 0,    3,    32'h55,  32'h57};
    vecs[7] = '{1'b0, 12'h1FF, 13'd5,    1, 32'h0,  5,    5,    32'h1FF, 32'h203};
    vecs[8] = '{1'b0, 12'h800, 13'd4096, 0, 32'h0,  4096, 4096, 32'h800, 32'h7FF};
    after_rst = '{1'b0, 12'h040, 13'd2, 0, 32'h0, 2, 2, 32'h40, 32'h41};
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'(i);

    reset = 1'b1; preload = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_count = '0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy_done", {bus.busy, bus.done}, 2'b00);
    chk("rst_mem_ctrl", {bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.mem_byteenable}, 7'h0);
    chk("rst_mem_addr", bus.mem_address, 12'h0);
    chk("rst_mem_wdata", bus.mem_writedata, 32'h0);
    chk("rst_streams", {bus.out_valid, bus.out_last, bus.in_ready}, 3'b000);
    preload = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk("clken_after_reset", bus.mem_clken, 1);

    for (int i = 0; i < 9; i++) run_cmd(i, vecs[i]);

    // reset in the middle of an 8-word read, after three beats
    @(negedge clk);
    bus.cmd_write = 1'b0; bus.cmd_addr = 12'h300; bus.cmd_count = 13'd8; bus.out_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 3; c++) begin
      if (c != 0) @(negedge clk);
      bus.cmd_valid = (c == 0);
      if (bus.out_valid) begin
        chk("pre_reset_data", bus.out_data, 32'h300 + 32'(beats));
        beats++;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("pre_reset_beats", beats, 3);
    @(negedge clk);
    chk("pre_reset_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_cmd_ready_busy", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
    chk("midrst_mem_ctrl", {bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.mem_byteenable}, 7'h0);
    chk("midrst_mem_addr_data", {bus.mem_address, bus.mem_writedata}, 44'h0);
    chk("midrst_streams", {bus.out_valid, bus.out_last, bus.in_ready}, 3'b000);
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_cmd(9, after_rst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
